// File: rtl/uart_hex_formatter.sv
// Formats one binary word as uppercase ASCII hex (MSB first, optional CR LF) and
// hands the characters one at a time to a UART transmitter's start/wait interface.
module uart_hex_formatter #(
    parameter int unsigned WIDTH   = 17,
    parameter int unsigned NEWLINE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [7:0]       tx_d,
    output logic             tx_start,
    input  logic             tx_wait
);

    localparam int unsigned NDIG  = (WIDTH + 3) / 4;
    localparam int unsigned SW    = 4 * NDIG;
    localparam int unsigned TOTAL = NDIG + 2 * NEWLINE;
    // Wide enough to hold TOTAL itself so comparisons against NDIG never truncate.
    localparam int unsigned IDXW  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {StIdle, StSend, StGuard, StWait} state_e;

    state_e          state_q;
    logic [SW-1:0]   sreg_q;
    logic [IDXW-1:0] idx_q;
    logic [7:0]      tx_d_q;
    logic            tx_start_q;

    logic [SW-1:0]   word_ext;
    logic [SW-1:0]   sreg_shift;
    logic [IDXW-1:0] idx_next;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign word_ext   = SW'(word);
    assign sreg_shift = sreg_q << 4;
    assign idx_next   = idx_q + IDXW'(1);

    assign word_ready = (state_q == StIdle) && !rst;
    assign tx_d       = tx_d_q;
    assign tx_start   = tx_start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            idx_q      <= '0;
            tx_d_q     <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (word_valid) begin
                        sreg_q     <= word_ext;
                        idx_q      <= '0;
                        tx_d_q     <= hex_char(word_ext[SW-1 -: 4]);
                        tx_start_q <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend:  state_q <= StGuard;
                // The transmitter raises tx_wait during this cycle, so it is not sampled here.
                StGuard: state_q <= StWait;
                StWait: begin
                    if (!tx_wait) begin
                        if (idx_q == IDXW'(TOTAL - 1)) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q      <= idx_next;
                            tx_start_q <= 1'b1;
                            state_q    <= StSend;
                            if (idx_next < IDXW'(NDIG)) begin
                                tx_d_q <= hex_char(sreg_shift[SW-1 -: 4]);
                                sreg_q <= sreg_shift;
                            end else if (idx_next == IDXW'(NDIG)) begin
                                tx_d_q <= 8'h0D;
                            end else begin
                                tx_d_q <= 8'h0A;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Scoreboard bench: two formatter configurations driven against a simple UART
// transmitter model; expected characters are queued at issue and checked on tx_start.
module tb_uart_hex_formatter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [16:0] word;
    logic        word_valid, word_ready, tx_start, tx_wait;
    logic [7:0]  tx_d;

    logic [7:0]  b_word;
    logic        b_valid, b_ready, b_start, b_wait;
    logic [7:0]  b_d;

    uart_hex_formatter #(.WIDTH(17), .NEWLINE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx_d       (tx_d),
        .tx_start   (tx_start),
        .tx_wait    (tx_wait)
    );

    uart_hex_formatter #(.WIDTH(8), .NEWLINE(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .word       (b_word),
        .word_valid (b_valid),
        .word_ready (b_ready),
        .tx_d       (b_d),
        .tx_start   (b_start),
        .tx_wait    (b_wait)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter models: busy for a frame starting the cycle after tx_start is sampled.
    int busy = 0, next_len = 20, b_busy = 0;
    always @(posedge clk) begin
        if (tx_start && busy == 0) busy <= next_len;
        else if (busy > 0)         busy <= busy - 1;
        if (b_start && b_busy == 0) b_busy <= 20;
        else if (b_busy > 0)        b_busy <= b_busy - 1;
    end
    assign tx_wait = (busy != 0);
    assign b_wait  = (b_busy != 0);

    typedef struct {
        logic [7:0] ch;
        bit         first;
    } exp_t;

    exp_t       q[$];
    logic [7:0] b_q[$];
    int         pulses = 0, b_pulses = 0, cyc = 0, last_high = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                pulses++;
                check("start_while_tx_idle", {31'd0, tx_wait}, 32'd0);
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: got tx_d 0x%0h, expected no pulse", tx_d);
                end else begin
                    e = q.pop_front();
                    check("tx_d", {24'd0, tx_d}, {24'd0, e.ch});
                    if (!e.first) check("issue_gap", cyc - last_high, 2);
                end
            end
            if (tx_wait) last_high = cyc;
            if (b_start) begin
                b_pulses++;
                check("b_start_while_tx_idle", {31'd0, b_wait}, 32'd0);
                if (b_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected_start: got tx_d 0x%0h, expected no pulse", b_d);
                end else begin
                    check("b_tx_d", {24'd0, b_d}, {24'd0, b_q.pop_front()});
                end
            end
        end
    end

    task automatic put_word(input logic [16:0] w, input string s, input bit hold);
        int budget = 0;
        @(negedge clk);
        word       = w;
        word_valid = 1'b1;
        while (!word_ready && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check("accept_in_time", {31'd0, word_ready}, 32'd1);
        check("prev_word_drained", q.size(), 0);
        check("idle_tx_wait_low", {31'd0, tx_wait}, 32'd0);
        for (int i = 0; i < s.len(); i++) q.push_back('{ch: s[i], first: (i == 0)});
        @(negedge clk);
        check("start_latency", {31'd0, tx_start}, 32'd1);
        check("ready_low_busy", {31'd0, word_ready}, 32'd0);
        if (!hold) word_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget = 0;
        while (!(q.size() == 0 && word_ready && !tx_wait) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check(name, {31'd0, word_ready}, 32'd1);
    endtask

    task automatic wait_pulses(input int target);
        int budget = 0;
        while (pulses < target && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check("pulse_reached", {31'd0, pulses >= target}, 32'd1);
    endtask

    int p, budget;

    initial begin
        rst = 1'b1; word = '0; word_valid = 1'b0; b_word = '0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_d", {24'd0, tx_d}, 32'd0);
        check("rst_ready_low", {31'd0, word_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, word_ready}, 32'd1);
        check("b_ready_after_rst", {31'd0, b_ready}, 32'd1);

        // Basic word with CR LF.
        p = pulses;
        put_word(17'h1ABCD, "1ABCD\r\n", 1'b0);
        wait_done("word1_done");
        check("word1_pulses", pulses - p, 7);

        // Back-to-back with valid held.
        p = pulses;
        put_word(17'h00000, "00000\r\n", 1'b1);
        put_word(17'h1FFFF, "1FFFF\r\n", 1'b0);
        wait_done("b2b_done");
        check("b2b_pulses", pulses - p, 14);

        // Input word changes after accept.
        p = pulses;
        put_word(17'h12345, "12345\r\n", 1'b0);
        wait_pulses(p + 2);
        word = 17'h0FFFF;
        wait_done("word_change_done");

        // Reset while waiting on the third character.
        p = pulses;
        put_word(17'h1ABCD, "1ABCD\r\n", 1'b0);
        wait_pulses(p + 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        check("midrst_tx_d", {24'd0, tx_d}, 32'd0);
        check("midrst_ready_low", {31'd0, word_ready}, 32'd0);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("ready_after_midrst", {31'd0, word_ready}, 32'd1);
        budget = 0;
        while (tx_wait && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("no_pulse_after_rst", pulses - p, 3);
        put_word(17'h00007, "00007\r\n", 1'b0);
        wait_done("after_rst_done");

        // Long transmitter stall on the first character.
        p = pulses;
        next_len = 5000;
        put_word(17'h00ABC, "00ABC\r\n", 1'b0);
        wait_pulses(p + 1);
        next_len = 20;
        wait_done("stall_done");
        check("stall_pulses", pulses - p, 7);

        // Second configuration: 8-bit word, no newline.
        @(negedge clk);
        b_word  = 8'h9F;
        b_valid = 1'b1;
        b_q.push_back(8'h39);
        b_q.push_back(8'h46);
        @(negedge clk);
        check("b_start_latency", {31'd0, b_start}, 32'd1);
        b_valid = 1'b0;
        budget = 0;
        while (!(b_ready && !b_wait && b_q.size() == 0) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        repeat (30) @(negedge clk);
        check("b_pulses", b_pulses, 2);
        check("b_idle_ready", {31'd0, b_ready}, 32'd1);

        check("queue_empty", q.size(), 0);
        check("b_queue_empty", b_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_hex_formatter.md
Name: uart_hex_formatter

Overview:
- Upstream feeder for the UART transmitter. Accepts one binary word at a time (for example an EDSAC memory or accumulator value) over a valid/ready handshake.
- Converts the word to uppercase ASCII hex, MSB first, optionally followed by CR LF.
- Emits one byte at a time to the transmitter using its start/wait interface.
- Lets debug and console paths print words without a CPU-side formatter.

Parameters:
- WIDTH, 17: width of the input word in bits. Legal range 1..32.
- NEWLINE, 1: if 1, append 0x0D 0x0A after the hex digits; if 0, send digits only.
- (derived) NDIG = ceil(WIDTH/4): number of hex digits sent. The word is zero-extended to 4*NDIG bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- word  in  WIDTH  value to print; sampled only on accept.
- word_valid  in  1  upstream has a word.
- word_ready  out  1  block can accept a word (high only in IDLE, and low while rst=1).
- tx_d  out  8  character to the transmitter; held stable from SEND until the next SEND.
- tx_start  out  1  single-cycle request to the transmitter; high only in SEND.
- tx_wait  in  1  transmitter busy flag. It goes high the cycle after the transmitter samples tx_start and drops when the stop bit ends.

Behaviour:
- Reset values: state=IDLE, tx_start=0, tx_d=0x00, word_ready=0 while rst=1, word_ready=1 on the first cycle after rst falls. Shift register and char index are cleared to 0.
- Accept: a word is accepted on any edge with word_valid & word_ready. On that edge: shift reg <= zero-extended word, index <= 0, tx_d <= ASCII of the top nibble, state <= SEND.
- Digit encoding: nibble 0-9 maps to 0x30+n; nibble 10-15 maps to 0x41+(n-10). There is no '0x' prefix and no leading-zero suppression.
- Characters per word: TOTAL = NDIG + 2*NEWLINE.
- State machine (four states):
  - IDLE: word_ready=1. Moves to SEND on accept.
  - SEND: tx_start=1 for exactly this one cycle. Next state is GUARD.
  - GUARD: one cycle, ignores tx_wait, which the transmitter is raising this cycle. Next state is WAIT.
  - WAIT: holds while tx_wait=1. When tx_wait=0: if index == TOTAL-1, go to IDLE; otherwise index+1, load tx_d with the next character (next nibble, or 0x0D then 0x0A after the last digit), and go to SEND.
- Latency: tx_start rises one cycle after the accept edge. Each character occupies 1 (SEND) + 1 (GUARD) + transmitter frame time.
- word_ready returns high the cycle after WAIT sees tx_wait=0 on the last character. The next word can then be accepted on that same cycle; there is no extra bubble.
- word_valid while busy: ignored, and word_ready stays 0. The word is neither captured nor dropped; upstream must hold it.
- Changes on word after accept have no effect on the current output.
- tx_wait=1 observed in IDLE (transmitter busy from another source): the block still accepts. SEND is issued only from the captured state, so the integrator must not share the transmitter.
- Reset mid-word: the next edge forces IDLE, tx_start=0, tx_d=0x00. The remaining characters are discarded; no partial CR/LF is sent.
- WIDTH not a multiple of 4: the top digit carries only the upper WIDTH mod 4 bits. With WIDTH=17 the top digit is '0' or '1'.
- The index counter is wide enough for TOTAL-1 and never wraps in normal operation.

Test Plan:
- WIDTH=17, NEWLINE=1, word=0x1ABCD, transmitter model with wait high for 20 cycles per char -> tx_d sequence 0x31,0x41,0x42,0x43,0x44,0x0D,0x0A. Exactly 7 one-cycle tx_start pulses, each only when tx_wait was low. word_ready high again after the 7th.
- Words 0x00000 then 0x1FFFF back-to-back, valid held continuously -> "00000\r\n1FFFF\r\n". The second accept occurs on the first IDLE cycle. word_ready=0 throughout the first word.
- NEWLINE=0, WIDTH=8, word=0x9F -> exactly 2 pulses: 0x39,0x46. Then IDLE.
- Change word input to 0x0FFFF while the 2nd char of 0x12345 is in flight -> output remains "12345\r\n".
- Assert rst for 1 cycle while in WAIT on the 3rd char -> next cycle tx_start=0, tx_d=0x00, no further pulses. After rst falls, word_ready=1 and a new word 0x00007 prints "00007\r\n".
- Hold tx_wait high for 5000 cycles after a start -> no additional tx_start during the stall. The next char issues 1 cycle after tx_wait falls.
